// File: rtl/clock_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_ctrl
// Brief    : Runtime-programmable glitch-free clock divider controller; ratio
//            and run/stop changes are applied only at a falling edge of clk_out.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 1,
    parameter bit RST_ENABLE   = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic             cfg_enable,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             active,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_DEFAULT_HALF = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);
    localparam state_t           C_RST_STATE    = RST_ENABLE ? ST_RUN : ST_IDLE;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_pend_en;
    logic             r_clk;
    logic             r_rise;
    logic             r_err;
    logic             r_ready;
    logic             r_active;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_half_nxt;
    logic [CNT_W-1:0] w_pend_half_nxt;
    logic             w_pend_en_nxt;
    logic             w_clk_nxt;
    logic             w_err_nxt;
    logic             w_accept;
    logic             w_legal;
    logic             w_tick;
    logic [CNT_W-1:0] w_half_m1;

    assign w_accept  = cfg_valid && r_ready;
    assign w_legal   = (cfg_half_period != '0);
    assign w_half_m1 = r_half - C_ONE;
    assign w_tick    = (r_count == w_half_m1);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_half_nxt      = r_half;
        w_pend_half_nxt = r_pend_half;
        w_pend_en_nxt   = r_pend_en;
        w_clk_nxt       = r_clk;
        w_err_nxt       = w_accept && !w_legal;

        // Shared half-period counter used by RUN and DRAIN
        if (w_tick) begin
            w_count_nxt = '0;
            w_clk_nxt   = ~r_clk;
        end else begin
            w_count_nxt = r_count + C_ONE;
        end

        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                w_clk_nxt   = 1'b0;
                if (w_accept && w_legal) begin
                    w_half_nxt  = cfg_half_period;
                    w_state_nxt = cfg_enable ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_accept && w_legal) begin
                    w_pend_half_nxt = cfg_half_period;
                    w_pend_en_nxt   = cfg_enable;
                    w_state_nxt     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Apply only on the falling edge so neither phase is truncated
                if (w_tick && r_clk) begin
                    w_clk_nxt   = 1'b0;
                    w_count_nxt = '0;
                    w_half_nxt  = r_pend_half;
                    w_state_nxt = r_pend_en ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= C_RST_STATE;
            r_count     <= '0;
            r_half      <= C_DEFAULT_HALF;
            r_pend_half <= C_DEFAULT_HALF;
            r_pend_en   <= 1'b0;
            r_clk       <= 1'b0;
            r_rise      <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
            r_active    <= RST_ENABLE;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_half      <= w_half_nxt;
            r_pend_half <= w_pend_half_nxt;
            r_pend_en   <= w_pend_en_nxt;
            r_clk       <= w_clk_nxt;
            r_rise      <= w_clk_nxt && !r_clk;
            r_err       <= w_err_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
            r_active    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
        end
    end

    assign cfg_ready  = r_ready;
    assign clk_out    = r_clk;
    assign rise_pulse = r_rise;
    assign active     = r_active;
    assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_ctrl
// Brief    : Directed self-checking bench for clock_divider_ctrl (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_ctrl;

    localparam int C_CNT_W = 16;

    logic               clk_in = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [C_CNT_W-1:0] cfg_half_period = '0;
    logic               cfg_enable = 1'b0;
    logic               clk_out;
    logic               rise_pulse;
    logic               active;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    clock_divider_ctrl #(
        .CNT_W        (C_CNT_W),
        .DEFAULT_HALF (1),
        .RST_ENABLE   (1'b1)
    ) u_dut (
        .clk_in          (clk_in),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_half_period (cfg_half_period),
        .cfg_enable      (cfg_enable),
        .clk_out         (clk_out),
        .rise_pulse      (rise_pulse),
        .active          (active),
        .cfg_err         (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clk_in edge and settle; inputs change and outputs are read here
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        do_reset();
        obs = {clk_out, rise_pulse, cfg_err, active};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0001", obs);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", cfg_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (clk_out !== ((i % 2) == 0) || rise_pulse !== ((i % 2) == 0) ||
                active !== 1'b1 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_div2 cyc=%0d got clk=%b rise=%b act=%b rdy=%b exp clk=%b",
                         i, clk_out, rise_pulse, active, cfg_ready, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_h1_to_h3();
        logic e_clk  [0:11];
        logic e_rise [0:11];
        logic e_rdy  [0:11];
        e_clk  = '{0,1,0,0,0,1,1,1,0,0,0,1};
        e_rise = '{0,1,0,0,0,1,0,0,0,0,0,1};
        e_rdy  = '{0,0,1,1,1,1,1,1,1,1,1,1};
        do_reset();
        step();
        cfg_valid = 1'b1;
        cfg_half_period = 16'd3;
        cfg_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if (clk_out !== e_clk[i] || rise_pulse !== e_rise[i] ||
                cfg_ready !== e_rdy[i] || active !== 1'b1) begin
                errors++;
                $display("FAIL h1_to_h3 cyc=%0d got clk=%b rise=%b rdy=%b act=%b exp clk=%b rise=%b rdy=%b act=1",
                         i, clk_out, rise_pulse, cfg_ready, active, e_clk[i], e_rise[i], e_rdy[i]);
            end
        end
    endtask

    // Continues from test_h1_to_h3: H=3, clk_out just rose
    task automatic test_stop_mid_high();
        logic e_clk [0:6];
        logic e_rdy [0:6];
        e_clk = '{1,1,0,0,0,0,1};
        e_rdy = '{0,0,1,1,1,1,1};
        cfg_valid = 1'b1;
        cfg_half_period = 16'd4;
        cfg_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if (clk_out !== e_clk[i] || cfg_ready !== e_rdy[i]) begin
                errors++;
                $display("FAIL h3_to_h4 cyc=%0d got clk=%b rdy=%b exp clk=%b rdy=%b",
                         i, clk_out, cfg_ready, e_clk[i], e_rdy[i]);
            end
        end
        cfg_valid = 1'b1;
        cfg_enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if (clk_out !== (i < 3) || active !== (i < 3) || rise_pulse !== 1'b0) begin
                errors++;
                $display("FAIL stop_mid_high cyc=%0d got clk=%b act=%b rise=%b exp clk=%b act=%b rise=0",
                         i, clk_out, active, rise_pulse, i < 3, i < 3);
            end
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got=%b exp=1", cfg_ready);
        end
    endtask

    task automatic test_idle_start();
        logic e_clk  [0:8];
        logic e_rise [0:8];
        e_clk  = '{0,0,1,1,0,0,1,1,0};
        e_rise = '{0,0,1,0,0,0,1,0,0};
        cfg_valid = 1'b1;
        cfg_half_period = 16'd2;
        cfg_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if (clk_out !== e_clk[i] || rise_pulse !== e_rise[i] ||
                active !== 1'b1 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_start cyc=%0d got clk=%b rise=%b act=%b rdy=%b exp clk=%b rise=%b act=1 rdy=1",
                         i, clk_out, rise_pulse, active, cfg_ready, e_clk[i], e_rise[i]);
            end
        end
    endtask

    // Continues from test_idle_start: H=2, clk_out just fell
    task automatic test_illegal_cfg();
        logic e_clk [0:5];
        e_clk = '{0,1,1,0,0,1};
        cfg_valid = 1'b1;
        cfg_half_period = 16'd0;
        cfg_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if (clk_out !== e_clk[i] || cfg_err !== (i == 0) ||
                cfg_ready !== 1'b1 || active !== 1'b1) begin
                errors++;
                $display("FAIL illegal_cfg cyc=%0d got clk=%b err=%b rdy=%b act=%b exp clk=%b err=%b",
                         i, clk_out, cfg_err, cfg_ready, active, e_clk[i], i == 0);
            end
        end
    endtask

    // Continues from test_illegal_cfg: H=2, clk_out just rose
    task automatic test_reset_in_drain();
        cfg_valid = 1'b1;
        cfg_half_period = 16'd5;
        cfg_enable = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL drain_entry got rdy=%b act=%b exp rdy=0 act=1", cfg_ready, active);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (clk_out !== 1'b0 || cfg_ready !== 1'b1 || rise_pulse !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset got clk=%b rdy=%b rise=%b exp clk=0 rdy=1 rise=0",
                     clk_out, cfg_ready, rise_pulse);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (clk_out !== ((i % 2) == 0) || rise_pulse !== ((i % 2) == 0) || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_div cyc=%0d got clk=%b rise=%b rdy=%b exp clk=%b rdy=1",
                         i, clk_out, rise_pulse, cfg_ready, (i % 2) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_h1_to_h3();
        test_stop_mid_high();
        test_idle_start();
        test_illegal_cfg();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
